// File: rtl/mem_pipe_multicycle.sv
// rtl/mem_pipe_multicycle.sv - fully pipelined multi-cycle single-port word memory
//
// Ports:
//   clk        in   1        rising-edge clock
//   rst        in   1        synchronous active-high reset (clears pipeline, not the array)
//   enable     in   1        request valid this cycle
//   wr         in   1        1 = write, 0 = read
//   addr       in   ADDR_W   byte address; word index = addr[WORDS_LOG2:1]
//   data_in    in   DATA_W   write data
//   data_out   out  DATA_W   returning read word, 0 when data_valid=0
//   data_valid out  1        one-cycle strobe per returning read
//   pending    out  4        reads issued but not yet returned

module mem_pipe_multicycle #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int WORDS_LOG2 = 15,
    parameter int LATENCY    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic [3:0]        pending
);

    if (LATENCY < 1 || LATENCY > 8) begin : g_latency_check
        $error("mem_pipe_multicycle: LATENCY must be in 1..8");
    end

    localparam int DEPTH = 1 << WORDS_LOG2;

    logic [DATA_W-1:0]     mem_array [DEPTH];
    logic [WORDS_LOG2-1:0] word_idx;
    logic                  rd_issue;
    logic                  wr_issue;

    logic [LATENCY-1:0]    valid_q, valid_d;
    logic [DATA_W-1:0]     data_q [LATENCY];
    logic [DATA_W-1:0]     data_d [LATENCY];
    logic [3:0]            pending_q, pending_d;

    // Byte-lane bit is meaningless for a word array; upper bits alias.
    logic unused_addr;
    assign unused_addr = addr[0];

    assign word_idx = addr[WORDS_LOG2:1];
    // Requests presented during reset are dropped, including writes.
    assign rd_issue = enable & ~wr & ~rst;
    assign wr_issue = enable &  wr & ~rst;

    always_ff @(posedge clk) begin
        if (wr_issue) begin
            mem_array[word_idx] <= data_in;
        end
    end

    // Read data is captured at issue, so a write on a later edge cannot
    // disturb a read already travelling down the pipeline.
    always_comb begin
        valid_d    = '0;
        valid_d[0] = rd_issue;
        for (int i = 0; i < LATENCY; i++) begin
            data_d[i] = '0;
        end
        data_d[0] = rd_issue ? mem_array[word_idx] : '0;
        for (int i = 1; i < LATENCY; i++) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = data_q[i-1];
        end
        // A read leaving the output stage on the same edge as a new issue
        // leaves the count unchanged.
        pending_d = pending_q + {3'b000, rd_issue} - {3'b000, valid_q[LATENCY-1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= '0;
            pending_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            pending_q <= pending_d;
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign data_valid = valid_q[LATENCY-1];
    assign data_out   = valid_q[LATENCY-1] ? data_q[LATENCY-1] : '0;
    assign pending    = pending_q;

endmodule

// File: tb/tb_mem_pipe_multicycle.sv
// tb/tb_mem_pipe_multicycle.sv - scoreboard bench for mem_pipe_multicycle

module tb_mem_pipe_multicycle;

    localparam int LAT = 4;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        data_valid;
    logic [3:0]  pending;

    mem_pipe_multicycle #(
        .ADDR_W(16), .DATA_W(16), .WORDS_LOG2(15), .LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr),
        .data_in(data_in), .data_out(data_out), .data_valid(data_valid),
        .pending(pending)
    );

    typedef struct {
        int          due;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] model_mem [0:32767];
    int          cyc;
    int          checks;
    int          errors;
    logic        mon_en;
    logic        mon_v;
    logic [15:0] mon_d;
    int          mon_p;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge with the given request; model and scoreboard follow
    // the behaviour the memory is required to have at that edge.
    task automatic step(input logic en, input logic w, input logic [15:0] a,
                        input logic [15:0] d, input logic r);
        rst     = r;
        enable  = en;
        wr      = w;
        addr    = a;
        data_in = d;
        @(posedge clk);
        cyc++;
        if (r) begin
            sb.delete();
        end else if (en && !w) begin
            sb.push_back('{due: cyc + LAT - 1, data: model_mem[a[15:1]]});
        end else if (en && w) begin
            model_mem[a[15:1]] = d;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    // Scoreboard: every cycle the expected strobe/data/pending are compared.
    always @(negedge clk) begin
        if (mon_en) begin
            mon_v = 1'b0;
            mon_d = 16'h0;
            mon_p = sb.size();
            if (sb.size() > 0 && sb[0].due == cyc) begin
                mon_v = 1'b1;
                mon_d = sb[0].data;
                void'(sb.pop_front());
            end
            checks++;
            if (data_valid !== mon_v || data_out !== mon_d) begin
                errors++;
                $display("FAIL scoreboard cyc=%0d: got valid=%b data=%h, expected valid=%b data=%h",
                         cyc, data_valid, data_out, mon_v, mon_d);
            end
            checks++;
            if (pending !== 4'(mon_p)) begin
                errors++;
                $display("FAIL pending_track cyc=%0d: got %0d, expected %0d", cyc, pending, mon_p);
            end
        end
    end

    task automatic test_reset();
        step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        checks++;
        if (data_valid !== 1'b0 || data_out !== 16'h0 || pending !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b data=%h pending=%0d, expected 0/0000/0",
                     data_valid, data_out, pending);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_single_read();
        step(1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
        idle(1);
        step(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0);
        idle(2);
        checks++;
        if (data_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early: got valid=%b, expected 0", data_valid);
        end
        idle(1);
        checks++;
        if (data_valid !== 1'b1 || data_out !== 16'hBEEF) begin
            errors++;
            $display("FAIL single_latency: got valid=%b data=%h, expected 1/beef", data_valid, data_out);
        end
        idle(LAT);
    endtask

    task automatic test_line_fill();
        int exp_p[12] = '{1, 2, 3, 4, 4, 4, 4, 4, 3, 2, 1, 0};
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 16'(16'h0100 + 2 * i), 16'(16'h1000 + i), 1'b0);
        idle(1);
        for (int i = 0; i < 12; i++) begin
            if (i < 8) step(1'b1, 1'b0, 16'(16'h0100 + 2 * i), 16'h0, 1'b0);
            else       idle(1);
            checks++;
            if (pending !== 4'(exp_p[i])) begin
                errors++;
                $display("FAIL fill_pending[%0d]: got %0d, expected %0d", i, pending, exp_p[i]);
            end
        end
        idle(2);
    endtask

    task automatic test_ordering();
        int strobes = 0;
        step(1'b1, 1'b1, 16'h0020, 16'h1111, 1'b0);
        idle(1);
        for (int i = 0; i < 9; i++) begin
            if (i == 0 || i == 2) step(1'b1, 1'b0, 16'h0020, 16'h0, 1'b0);
            else if (i == 1)      step(1'b1, 1'b1, 16'h0020, 16'h2222, 1'b0);
            else                  idle(1);
            if (data_valid === 1'b1) strobes++;
        end
        checks++;
        if (strobes != 2) begin
            errors++;
            $display("FAIL order_strobes: got %0d strobes, expected 2", strobes);
        end
        idle(2);
    endtask

    task automatic test_reset_flush();
        step(1'b1, 1'b0, 16'h0100, 16'h0, 1'b0);
        step(1'b1, 1'b0, 16'h0102, 16'h0, 1'b0);
        step(1'b1, 1'b0, 16'h0104, 16'h0, 1'b1);
        checks++;
        if (data_valid !== 1'b0 || data_out !== 16'h0 || pending !== 4'd0) begin
            errors++;
            $display("FAIL flush_state: got valid=%b data=%h pending=%0d, expected 0/0000/0",
                     data_valid, data_out, pending);
        end
        step(1'b1, 1'b1, 16'h0100, 16'hDEAD, 1'b1);
        idle(LAT + 2);
        step(1'b1, 1'b0, 16'h0100, 16'h0, 1'b0);
        idle(3);
        checks++;
        if (data_valid !== 1'b1 || data_out !== 16'h1000) begin
            errors++;
            $display("FAIL flush_array_kept: got valid=%b data=%h, expected 1/1000", data_valid, data_out);
        end
        idle(LAT);
    endtask

    task automatic test_alternate();
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) step(1'b1, 1'b0, 16'(16'h0100 + i), 16'h0, 1'b0);
            else            idle(1);
        end
        idle(LAT + 1);
    endtask

    task automatic test_alias();
        step(1'b1, 1'b0, 16'h0011, 16'h0, 1'b0);
        idle(3);
        checks++;
        if (data_valid !== 1'b1 || data_out !== 16'hBEEF) begin
            errors++;
            $display("FAIL odd_alias: got valid=%b data=%h, expected 1/beef", data_valid, data_out);
        end
        idle(LAT);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 32; i++) step(1'b1, 1'b1, 16'(16'h0200 + 2 * i), 16'($urandom), 1'b0);
        for (int i = 0; i < 60; i++) begin
            step(($urandom % 4) != 0, ($urandom % 4) == 0, 16'(16'h0200 + ($urandom % 64)),
                 16'($urandom), 1'b0);
        end
        idle(LAT + 2);
    endtask

    initial begin
        cyc     = 0;
        checks  = 0;
        errors  = 0;
        mon_en  = 1'b0;
        rst     = 1'b1;
        enable  = 1'b0;
        wr      = 1'b0;
        addr    = 16'h0;
        data_in = 16'h0;
        test_reset();
        test_single_read();
        test_line_fill();
        test_ordering();
        test_reset_flush();
        test_alternate();
        test_alias();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d reads never returned, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
